// File: rtl/pipe_hazard_ctrl.sv
// Stall/sequence controller for the five-stage pipeline.
// Combines register-dependency stalls (Tuse vs Tnew) with a small busy
// sequencer for the multi-cycle multiply/divide unit. A flush request
// overrides every stall. An MDU operation that has already started always
// runs to completion.
module pipe_hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       D_rs,
  input  logic [4:0]       D_rt,
  input  logic             D_use_rs,
  input  logic             D_use_rt,
  input  logic [1:0]       D_Tuse_rs,
  input  logic [1:0]       D_Tuse_rt,
  input  logic             D_md,
  input  logic [4:0]       E_A3,
  input  logic [1:0]       E_Tnew,
  input  logic [4:0]       M_A3,
  input  logic [1:0]       M_Tnew,
  input  logic             E_start,
  input  logic             E_is_div,
  input  logic             Req,
  output logic             stall,
  output logic             md_busy,
  output logic [CNT_W-1:0] md_cnt,
  output logic             md_done
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [0:0] state;
  logic       stall_rs;
  logic       stall_rt;
  logic       stall_md;

  // Operand hazards: a producer still further from ready than the consumer's
  // deadline forces a stall. $0 is never a real dependency.
  always_comb begin
    stall_rs = D_use_rs && (D_rs != 5'd0) &&
               (((E_A3 == D_rs) && (E_Tnew > D_Tuse_rs)) ||
                ((M_A3 == D_rs) && (M_Tnew > D_Tuse_rs)));
    stall_rt = D_use_rt && (D_rt != 5'd0) &&
               (((E_A3 == D_rt) && (E_Tnew > D_Tuse_rt)) ||
                ((M_A3 == D_rt) && (M_Tnew > D_Tuse_rt)));
    stall_md = D_md && (md_busy || E_start);
    stall    = (stall_rs || stall_rt || stall_md) && !Req;
  end

  // MDU status decoded from the sequencer; done marks the final busy cycle.
  always_comb begin
    md_busy = (state == ST_BUSY);
    md_done = md_busy && (md_cnt == CNT_ONE);
  end

  // MDU busy sequencer: load the latency on a non-flushed start, count down
  // to idle. Starts arriving while busy are ignored and never reload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      md_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (E_start && !Req) begin
            state  <= ST_BUSY;
            md_cnt <= E_is_div ? CNT_DIV : CNT_MULT;
          end
        end
        ST_BUSY: begin
          if (md_cnt == CNT_ONE) begin
            state  <= ST_IDLE;
            md_cnt <= '0;
          end else begin
            md_cnt <= md_cnt - CNT_ONE;
          end
        end
        default: begin
          state  <= ST_IDLE;
          md_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: a table of combinational hazard vectors plus
// hand-written MDU sequences (mult, div with mfhi waiting, flushed start,
// flush and illegal start mid-operation, reset mid-operation).
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic [4:0]       D_rs, D_rt;
  logic             D_use_rs, D_use_rt;
  logic [1:0]       D_Tuse_rs, D_Tuse_rt;
  logic             D_md;
  logic [4:0]       E_A3;
  logic [1:0]       E_Tnew;
  logic [4:0]       M_A3;
  logic [1:0]       M_Tnew;
  logic             E_start, E_is_div, Req;
  logic             stall, md_busy, md_done;
  logic [CNT_W-1:0] md_cnt;

  int n_vec;
  int n_bad;

  pipe_hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .D_rs(D_rs), .D_rt(D_rt), .D_use_rs(D_use_rs), .D_use_rt(D_use_rt),
    .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt), .D_md(D_md),
    .E_A3(E_A3), .E_Tnew(E_Tnew), .M_A3(M_A3), .M_Tnew(M_Tnew),
    .E_start(E_start), .E_is_div(E_is_div), .Req(Req),
    .stall(stall), .md_busy(md_busy), .md_cnt(md_cnt), .md_done(md_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic [1:0] tuse_rs;
    logic [1:0] tuse_rt;
    logic       md;
    logic [4:0] ea3;
    logic [1:0] etnew;
    logic [4:0] ma3;
    logic [1:0] mtnew;
    logic       req;
    logic       exp_stall;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    D_rs = 0; D_rt = 0; D_use_rs = 0; D_use_rt = 0;
    D_Tuse_rs = 0; D_Tuse_rt = 0; D_md = 0;
    E_A3 = 0; E_Tnew = 0; M_A3 = 0; M_Tnew = 0;
    E_start = 0; E_is_div = 0; Req = 0;
  endtask

  // Checks busy/cnt/done for one cycle of an MDU run.
  task automatic chk_md(input string nm, input logic b, input int c, input logic d);
    chk({nm, " busy"}, 32'(md_busy), 32'(b));
    chk({nm, " cnt"},  32'(md_cnt),  32'(c));
    chk({nm, " done"}, 32'(md_done), 32'(d));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    //             rs  rt use_rs use_rt trs trt md ea3 etn ma3 mtn req exp
    tbl[0]  = '{5'd8,  5'd0, 1, 0, 2'd1, 2'd0, 0, 5'd8,  2'd2, 5'd0,  2'd0, 0, 1}; // lw in E, add in D
    tbl[1]  = '{5'd8,  5'd0, 1, 0, 2'd1, 2'd0, 0, 5'd0,  2'd0, 5'd8,  2'd1, 0, 0}; // lw moved to M
    tbl[2]  = '{5'd0,  5'd0, 1, 0, 2'd0, 2'd0, 0, 5'd0,  2'd2, 5'd0,  2'd0, 0, 0}; // $0 never stalls
    tbl[3]  = '{5'd0,  5'd9, 0, 1, 2'd0, 2'd0, 0, 5'd0,  2'd0, 5'd9,  2'd0, 0, 0}; // Tnew 0
    tbl[4]  = '{5'd0,  5'd9, 0, 1, 2'd0, 2'd0, 0, 5'd0,  2'd0, 5'd9,  2'd1, 0, 1}; // M hazard on rt
    tbl[5]  = '{5'd0,  5'd9, 0, 0, 2'd0, 2'd0, 0, 5'd0,  2'd0, 5'd9,  2'd1, 0, 0}; // rt not read
    tbl[6]  = '{5'd8,  5'd0, 1, 0, 2'd1, 2'd0, 0, 5'd8,  2'd2, 5'd0,  2'd0, 1, 0}; // flush wins
    tbl[7]  = '{5'd5,  5'd0, 1, 0, 2'd0, 2'd0, 0, 5'd5,  2'd1, 5'd0,  2'd0, 0, 1}; // branch needs in D
    tbl[8]  = '{5'd5,  5'd0, 1, 0, 2'd2, 2'd0, 0, 5'd5,  2'd2, 5'd0,  2'd0, 0, 0}; // Tnew==Tuse
    tbl[9]  = '{5'd0,  5'd7, 0, 1, 2'd0, 2'd1, 0, 5'd7,  2'd2, 5'd0,  2'd0, 0, 1}; // E hazard on rt
    tbl[10] = '{5'd3,  5'd0, 1, 0, 2'd0, 2'd0, 0, 5'd4,  2'd2, 5'd0,  2'd0, 0, 0}; // different reg
    tbl[11] = '{5'd0,  5'd31,0, 1, 2'd0, 2'd0, 0, 5'd31, 2'd0, 5'd31, 2'd2, 0, 1}; // M path only
    tbl[12] = '{5'd0,  5'd0, 0, 0, 2'd0, 2'd0, 1, 5'd0,  2'd0, 5'd0,  2'd0, 0, 0}; // md idle
    tbl[13] = '{5'd6,  5'd0, 1, 0, 2'd2, 2'd0, 0, 5'd6,  2'd3, 5'd0,  2'd0, 0, 1}; // Tnew 3 > 2

    idle_inputs();
    reset = 1'b1;
    #2;
    chk_md("reset", 0, 0, 0);
    chk("reset stall", 32'(stall), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Combinational hazard table.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      idle_inputs();
      D_rs = tbl[i].rs; D_rt = tbl[i].rt;
      D_use_rs = tbl[i].use_rs; D_use_rt = tbl[i].use_rt;
      D_Tuse_rs = tbl[i].tuse_rs; D_Tuse_rt = tbl[i].tuse_rt;
      D_md = tbl[i].md;
      E_A3 = tbl[i].ea3; E_Tnew = tbl[i].etnew;
      M_A3 = tbl[i].ma3; M_Tnew = tbl[i].mtnew;
      Req = tbl[i].req;
      #1;
      chk($sformatf("vec%0d stall", i), 32'(stall), 32'(tbl[i].exp_stall));
    end

    // mult: busy cycles 1..5, done in cycle 5, idle in 6.
    @(negedge clk);
    idle_inputs();
    E_start = 1; E_is_div = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      E_start = 0;
      #1;
      if (c <= 5) chk_md($sformatf("mult c%0d", c), 1, 6 - c, c == 5);
      else        chk_md("mult idle", 0, 0, 0);
    end

    // div with mfhi held in D: stalls through start cycle and 10 busy cycles.
    @(negedge clk);
    idle_inputs();
    E_start = 1; E_is_div = 1; D_md = 1;
    #1;
    chk("div start stall", 32'(stall), 1);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      E_start = 0;
      #1;
      if (c <= 10) begin
        chk($sformatf("div c%0d stall", c), 32'(stall), 1);
        chk_md($sformatf("div c%0d", c), 1, 11 - c, c == 10);
      end else begin
        chk("div end stall", 32'(stall), 0);
        chk_md("div idle", 0, 0, 0);
      end
    end

    // Start with flush in the same cycle is suppressed; flush also clears stall.
    @(negedge clk);
    idle_inputs();
    E_start = 1; Req = 1; D_md = 1;
    #1;
    chk("flush start stall", 32'(stall), 0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk_md("flush start", 0, 0, 0);

    // mult with illegal restart in cycle 2 and flush in cycle 3: runs to done.
    @(negedge clk);
    idle_inputs();
    E_start = 1; E_is_div = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      E_start  = (c == 2);
      E_is_div = (c == 2);
      Req      = (c == 3);
      #1;
      if (c <= 5) chk_md($sformatf("mreq c%0d", c), 1, 6 - c, c == 5);
      else        chk_md("mreq idle", 0, 0, 0);
    end

    // Reset in cycle 2 of a mult clears the MDU at once; no done afterwards.
    @(negedge clk);
    idle_inputs();
    E_start = 1; E_is_div = 0;
    @(negedge clk);
    E_start = 0;
    #1;
    chk_md("rst c1", 1, 5, 0);
    @(negedge clk);
    #1;
    chk_md("rst c2 pre", 1, 4, 0);
    reset = 1'b1;
    #1;
    chk_md("rst c2 async", 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      chk_md($sformatf("rst after c%0d", c), 0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
